// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: latches the PC address, runs a bounded memory read,
// loads the instruction register and pulses the PC increment.
module instruction_fetch_unit #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int OP_W     = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    bus_in,
    output logic                 pc_enable,
    output logic                 pc_incr,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic                 mem_ready,
    input  logic [DATA_W-1:0]    mem_data,
    output logic [OP_W-1:0]      opcode,
    output logic                 ir_valid,
    output logic                 busy,
    output logic                 err,
    input  logic                 ir_enable,
    output logic [DATA_W-OP_W-1:0] operand_bus
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        READ,
        DONE,
        ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ir_valid_q, ir_valid_d;
    logic                err_q, err_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave it unassigned and infer a latch.
        state_d    = state_q;
        mar_d      = mar_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        ir_valid_d = ir_valid_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ADDR;
                    ir_valid_d = 1'b0;
                end
            end
            ADDR: begin
                mar_d   = bus_in;
                cnt_d   = '0;
                state_d = READ;
            end
            READ: begin
                // Ready wins over timeout, so the last permitted cycle still completes.
                if (mem_ready) begin
                    ir_d       = mem_data;
                    ir_valid_d = 1'b1;
                    state_d    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = ADDR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            mar_q      <= '0;
            ir_q       <= '0;
            cnt_q      <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
        end
    end

    // Moore outputs: decoded purely from registered state.
    assign pc_enable = (state_q == ADDR);
    assign mem_rd    = (state_q == READ);
    assign pc_incr   = (state_q == DONE);
    assign busy      = (state_q == ADDR) || (state_q == READ) || (state_q == DONE);
    assign err       = err_q;
    assign ir_valid  = ir_valid_q;
    assign mem_addr  = mar_q;
    assign opcode    = ir_q[DATA_W-1 -: OP_W];

    assign operand_bus = ir_enable ? ir_q[DATA_W-OP_W-1:0] : 'z;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus queues the expected
// completion of each fetch, a negedge monitor checks it when pc_incr or err fires.
module tb_instruction_fetch_unit;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int OP_W     = 4;
    localparam int OPND_W   = DATA_W - OP_W;
    localparam int MAX_WAIT = 15;

    logic                clk = 1'b0;
    logic                clr;
    logic                start;
    logic [ADDR_W-1:0]   bus_in;
    logic                pc_enable;
    logic                pc_incr;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_data;
    logic [OP_W-1:0]     opcode;
    logic                ir_valid;
    logic                busy;
    logic                err;
    logic                ir_enable;
    tri1  [OPND_W-1:0]   operand_bus;   // pulled high when the DUT releases it

    instruction_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .OP_W    (OP_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .bus_in     (bus_in),
        .pc_enable  (pc_enable),
        .pc_incr    (pc_incr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .opcode     (opcode),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .err        (err),
        .ir_enable  (ir_enable),
        .operand_bus(operand_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] ir;
    } exp_t;

    exp_t              sb_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] cur_ir   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flip ir_enable and check the bus follows the current IR low field or floats.
    task automatic toggle_operand(input string tag);
        ir_enable = ~ir_enable;
        #1;
        check({tag, " operand_bus"}, 32'(operand_bus),
              ir_enable ? 32'(cur_ir[OPND_W-1:0]) : 32'(4'hF));
    endtask

    // Monitor: every pc_incr pulse or err rising edge consumes one expectation.
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        if (clr) begin
            err_prev <= 1'b0;
        end else begin
            if (pc_incr || (err && !err_prev)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected completion", 32'(pc_incr), 32'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("mon kind err",  32'(err),      32'(e.is_err));
                    check("mon pc_incr",   32'(pc_incr),  32'(!e.is_err));
                    check("mon mem_addr",  32'(mem_addr), 32'(e.addr));
                    check("mon opcode",    32'(opcode),   32'(e.ir[DATA_W-1 -: OP_W]));
                    check("mon ir_valid",  32'(ir_valid), 32'(!e.is_err));
                end
            end
            check("mon rd_and_pcen", 32'(mem_rd && pc_enable), 32'(0));
            err_prev <= err;
        end
    end

    // One fetch; waits >= MAX_WAIT means ready never arrives.
    task automatic run_fetch(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                             input int waits, input bit spin_start);
        exp_t e;
        int   rd;
        bit   timeout;
        timeout  = (waits >= MAX_WAIT);
        e.is_err = timeout;
        e.addr   = addr;
        e.ir     = timeout ? cur_ir : data;
        sb_q.push_back(e);

        bus_in = addr;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("addr pc_enable", 32'(pc_enable), 32'(1));
        check("addr mem_rd",    32'(mem_rd),    32'(0));
        check("addr err",       32'(err),       32'(0));
        check("addr ir_valid",  32'(ir_valid),  32'(0));
        toggle_operand("addr");

        tick();
        bus_in = ~addr;
        check("read pc_enable", 32'(pc_enable), 32'(0));
        check("read mem_addr",  32'(mem_addr),  32'(addr));

        rd = 0;
        while (mem_rd && rd < MAX_WAIT + 4) begin
            mem_ready = (rd == waits);
            mem_data  = data;
            if (spin_start) start = rd[0];
            tick();
            rd++;
        end
        mem_ready = 1'b0;
        mem_data  = '0;
        start     = 1'b0;

        if (timeout) begin
            check("to read cycles", 32'(rd),      32'(MAX_WAIT));
            check("to err",         32'(err),     32'(1));
            check("to busy",        32'(busy),    32'(0));
            toggle_operand("err");
            for (int i = 0; i < 3; i++) begin
                tick();
                check("err hold",        32'(err),      32'(1));
                check("err hold pcinc",  32'(pc_incr),  32'(0));
                check("err hold opcode", 32'(opcode),   32'(cur_ir[DATA_W-1 -: OP_W]));
            end
        end else begin
            check("read cycles",  32'(rd),      32'(waits + 1));
            check("done pc_incr", 32'(pc_incr), 32'(1));
            check("done mem_rd",  32'(mem_rd),  32'(0));
            check("done err",     32'(err),     32'(0));
            cur_ir = data;
            toggle_operand("done");
            tick();
            check("idle pc_incr",  32'(pc_incr),  32'(0));
            check("idle busy",     32'(busy),     32'(0));
            check("idle ir_valid", 32'(ir_valid), 32'(1));
            toggle_operand("idle");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b1;
        start     = 1'b0;
        bus_in    = '0;
        mem_ready = 1'b0;
        mem_data  = '0;
        ir_enable = 1'b1;
        #3;
        check("rst busy",      32'(busy),      32'(0));
        check("rst pc_enable", 32'(pc_enable), 32'(0));
        check("rst mem_rd",    32'(mem_rd),    32'(0));
        check("rst ir_valid",  32'(ir_valid),  32'(0));
        check("rst opcode",    32'(opcode),    32'(0));
        check("rst operand",   32'(operand_bus), 32'(0));
        ir_enable = 1'b0;
        #1;
        check("rst operand z", 32'(operand_bus), 32'(4'hF));
        tick();
        tick();
        clr = 1'b0;
        tick();

        run_fetch(6'd5,    8'hA7, 0,  1'b0);      // zero wait
        run_fetch(6'h12,   8'h3C, 3,  1'b1);      // ready on 4th READ cycle, start spun
        run_fetch(6'h20,   8'h5B, 14, 1'b0);      // ready on the 15th READ cycle
        run_fetch(6'h2A,   8'h00, 99, 1'b0);      // timeout, IR keeps 5B
        run_fetch(6'h2A,   8'hC1, 1,  1'b0);      // retry from ERR
        run_fetch(6'd63,   8'h96, 0,  1'b0);
        run_fetch(6'd0,    8'h48, 2,  1'b0);

        // Asynchronous clear in the middle of a read.
        bus_in = 6'h11;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-clr mem_rd", 32'(mem_rd), 32'(1));
        ir_enable = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        check("clr mem_rd",    32'(mem_rd),      32'(0));
        check("clr busy",      32'(busy),        32'(0));
        check("clr pc_incr",   32'(pc_incr),     32'(0));
        check("clr pc_enable", 32'(pc_enable),   32'(0));
        check("clr ir_valid",  32'(ir_valid),    32'(0));
        check("clr err",       32'(err),         32'(0));
        check("clr opcode",    32'(opcode),      32'(0));
        check("clr mem_addr",  32'(mem_addr),    32'(0));
        check("clr operand z", 32'(operand_bus), 32'(4'hF));
        tick();
        clr    = 1'b0;
        cur_ir = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post-clr busy",    32'(busy),    32'(0));
            check("post-clr pc_incr", 32'(pc_incr), 32'(0));
        end

        check("scoreboard empty", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
